// File: rtl/uart_pkg.sv
// Shared register map, bit positions and TX state encoding for the UART FIFO bridge.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_LEVEL  = 2'd3;

  localparam int unsigned ST_RX_NE    = 0;
  localparam int unsigned ST_TX_NF    = 1;
  localparam int unsigned ST_PERR     = 2;
  localparam int unsigned ST_FERR     = 3;
  localparam int unsigned ST_OVF      = 4;
  localparam int unsigned ST_RX_DROP  = 5;
  localparam int unsigned ST_TX_IDLE  = 6;
  localparam int unsigned ST_RX_FULL  = 7;
  localparam int unsigned ST_TX_DROP  = 8;

  localparam int unsigned CT_RX_IE    = 0;
  localparam int unsigned CT_TX_IE    = 1;
  localparam int unsigned CT_ERR_IE   = 2;
  localparam int unsigned CT_TX_FLUSH = 3;
  localparam int unsigned CT_RX_FLUSH = 4;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} tx_state_t;

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// First-word fall-through synchronous FIFO with flush; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_out,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Port-mapped TX/RX FIFO bridge between the TramelBlaze I/O bus and the UART
// engines, with maskable multi-source interrupt and sticky drop status.
module uart_fifo_bridge #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_out,
  input  logic [15:0]       port_id,
  input  logic [15:0]       out_port,
  input  logic              write_strobe,
  input  logic              read_strobe,
  input  logic              interrupt_ack,
  output logic [15:0]       in_port,
  output logic              interrupt,
  output logic              tx_load,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_rdy,
  input  logic              rx_rdy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_perr,
  input  logic              rx_ferr,
  input  logic              rx_ovf,
  output logic              rx_clear
);
  import uart_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [15:0] offset;
  logic        hit, sel_data, sel_status, sel_ctrl;
  logic        wr_data, wr_ctrl, rd_data, rd_status;
  logic        rx_ie, tx_ie, err_ie;
  logic [7:0]  rx_thresh;
  logic [8:0]  thr_eff;
  logic        tx_flush, rx_flush;
  logic        unused_ctrl_bits;

  assign offset     = port_id - BASE_ADDR;
  assign hit        = (offset[15:2] == '0);
  assign sel_data   = hit && (offset[1:0] == REG_DATA);
  assign sel_status = hit && (offset[1:0] == REG_STATUS);
  assign sel_ctrl   = hit && (offset[1:0] == REG_CTRL);
  assign wr_data    = write_strobe & sel_data;
  assign wr_ctrl    = write_strobe & sel_ctrl;
  assign rd_data    = read_strobe & sel_data;
  assign rd_status  = read_strobe & sel_status;
  assign tx_flush   = wr_ctrl & out_port[CT_TX_FLUSH];
  assign rx_flush   = wr_ctrl & out_port[CT_RX_FLUSH];
  assign unused_ctrl_bits = ^out_port[7:5];

  // TX path
  logic [DATA_W-1:0] tx_head;
  logic [CW-1:0]     tx_count;
  logic              tx_full, tx_empty, tx_pop, tx_idle, tx_drop_evt, tx_drop;
  tx_state_t         state, state_nx;
  logic              seen_low, seen_low_nx;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_out(rst_out), .push(wr_data), .pop(tx_pop), .flush(tx_flush),
    .din(out_port[DATA_W-1:0]), .dout(tx_head), .count(tx_count),
    .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) begin
      state    <= IDLE;
      seen_low <= 1'b0;
    end else begin
      state    <= state_nx;
      seen_low <= seen_low_nx;
    end
  end

  // WAIT needs a full busy cycle (tx_rdy low, then high) before the next load
  always_comb begin
    state_nx    = state;
    seen_low_nx = seen_low;
    tx_load     = 1'b0;
    tx_pop      = 1'b0;
    case (state)
      IDLE: if (!tx_empty && tx_rdy) state_nx = LOAD;
      LOAD: begin
        tx_load     = 1'b1;
        tx_pop      = 1'b1;
        seen_low_nx = 1'b0;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (!tx_rdy)       seen_low_nx = 1'b1;
        else if (seen_low) state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx_data     = tx_load ? tx_head : '0;
  assign tx_idle     = tx_empty && (state == IDLE);
  assign tx_drop_evt = wr_data & tx_full & ~tx_pop;

  // RX path
  logic [DATA_W+2:0] rx_head;
  logic [CW-1:0]     rx_count;
  logic              rx_full, rx_empty, rx_pop, rx_rdy_q, rx_edge, rx_drop_evt, rx_drop;

  assign rx_edge     = rx_rdy & ~rx_rdy_q;
  assign rx_pop      = rd_data & ~rx_empty;
  assign rx_drop_evt = rx_edge & rx_full & ~rx_pop;

  sync_fifo #(.WIDTH(DATA_W + 3), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_out(rst_out), .push(rx_edge), .pop(rd_data), .flush(rx_flush),
    .din({rx_ovf, rx_ferr, rx_perr, rx_data}), .dout(rx_head), .count(rx_count),
    .full(rx_full), .empty(rx_empty)
  );

  // Control, sticky status and interrupt
  logic any_src, src_q, src_qq;

  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) begin
      rx_rdy_q  <= 1'b0;
      rx_clear  <= 1'b0;
      rx_drop   <= 1'b0;
      tx_drop   <= 1'b0;
      rx_ie     <= 1'b0;
      tx_ie     <= 1'b0;
      err_ie    <= 1'b0;
      rx_thresh <= '0;
      src_q     <= 1'b0;
      src_qq    <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      rx_rdy_q  <= rx_rdy;
      rx_clear  <= rx_edge;
      rx_drop   <= rx_drop_evt | (rx_drop & ~rd_status);
      tx_drop   <= tx_drop_evt | (tx_drop & ~rd_status);
      if (wr_ctrl) begin
        rx_ie     <= out_port[CT_RX_IE];
        tx_ie     <= out_port[CT_TX_IE];
        err_ie    <= out_port[CT_ERR_IE];
        rx_thresh <= out_port[15:8];
      end
      src_q     <= any_src;
      src_qq    <= src_q;
      interrupt <= (src_q & ~src_qq) | (interrupt & ~interrupt_ack);
    end
  end

  always_comb begin
    thr_eff = {1'b0, rx_thresh};
    if (rx_thresh == '0)             thr_eff = 9'd1;
    else if (thr_eff > 9'(DEPTH))    thr_eff = 9'(DEPTH);
  end

  assign any_src = (rx_ie & (9'(rx_count) >= thr_eff))
                 | (tx_ie & tx_idle)
                 | (err_ie & (rx_drop | tx_drop));

  logic [15:0] status;
  always_comb begin
    status             = '0;
    status[ST_RX_NE]   = ~rx_empty;
    status[ST_TX_NF]   = ~tx_full;
    status[ST_PERR]    = ~rx_empty & rx_head[DATA_W];
    status[ST_FERR]    = ~rx_empty & rx_head[DATA_W+1];
    status[ST_OVF]     = ~rx_empty & rx_head[DATA_W+2];
    status[ST_RX_DROP] = rx_drop;
    status[ST_TX_IDLE] = tx_idle;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_DROP] = tx_drop;
  end

  always_comb begin
    in_port = '0;
    if (hit) begin
      case (offset[1:0])
        REG_DATA:   if (!rx_empty) in_port = 16'(rx_head[DATA_W-1:0]);
        REG_STATUS: in_port = status;
        REG_CTRL:   in_port = {rx_thresh, 5'b0, err_ie, tx_ie, rx_ie};
        default:    in_port = {8'(tx_count), 8'(rx_count)};
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: queues of expected TX characters and
// RX reads, popped by monitors when the DUT presents tx_load or DATA read data.
module tb_uart_fifo_bridge;

  localparam logic [15:0] BASE = 16'h0010;
  localparam logic [1:0]  R_DATA = 2'd0, R_STATUS = 2'd1, R_CTRL = 2'd2, R_LEVEL = 2'd3;

  logic        clk = 1'b0;
  logic        rst_out;
  logic [15:0] port_id, out_port, in_port;
  logic        write_strobe, read_strobe, interrupt_ack, interrupt;
  logic        tx_load, tx_rdy, rx_rdy, rx_perr, rx_ferr, rx_ovf, rx_clear;
  logic [7:0]  tx_data, rx_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy = 0;
  int last_load = -1;
  int load_count = 0;
  logic tx_hold;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  uart_fifo_bridge #(.DATA_W(8), .DEPTH(16), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_out(rst_out), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .interrupt_ack(interrupt_ack), .in_port(in_port), .interrupt(interrupt),
    .tx_load(tx_load), .tx_data(tx_data), .tx_rdy(tx_rdy), .rx_rdy(rx_rdy),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_ovf(rx_ovf),
    .rx_clear(rx_clear)
  );

  always #5 clk = ~clk;

  // Transmit engine model: busy for 10 cycles after each load
  assign tx_rdy = ~tx_hold & (busy == 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_out)      busy <= 0;
    else if (tx_load) busy <= 10;
    else if (busy > 0) busy <= busy - 1;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_out && tx_load) begin
      load_count++;
      if (exp_tx.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_unexpected: got tx_load data %h expected no load", tx_data);
      end else begin
        check("tx_data", {8'h00, tx_data}, {8'h00, exp_tx.pop_front()});
      end
      if (last_load >= 0) check("tx_gap", 16'(cyc - last_load >= 12), 16'd1);
      last_load = cyc;
    end
  end

  always @(negedge clk) begin
    #2;
    if (read_strobe && port_id == BASE) begin
      if (exp_rx.size() == 0) begin
        tests++; fails++;
        $display("FAIL rx_unexpected: got %h expected no DATA read", in_port);
      end else begin
        check("rx_data", in_port, {8'h00, exp_rx.pop_front()});
      end
    end
  end

  task automatic wr(input logic [1:0] r, input logic [15:0] d);
    @(negedge clk);
    port_id = BASE + {14'b0, r}; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [1:0] r, output logic [15:0] d);
    @(negedge clk);
    port_id = BASE + {14'b0, r}; read_strobe = 1'b1;
    #1 d = in_port;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic rdchk(input logic [1:0] r, input logic [15:0] exp, input string name);
    logic [15:0] d;
    rd(r, d);
    check(name, d, exp);
  endtask

  task automatic inject(input logic [7:0] d, input logic p, input logic f, input logic o);
    @(negedge clk);
    rx_data = d; rx_perr = p; rx_ferr = f; rx_ovf = o; rx_rdy = 1'b1;
    @(negedge clk);
    rx_rdy = 1'b0;
    check("rx_clear_pulse", {15'b0, rx_clear}, 16'd1);
    @(negedge clk);
    check("rx_clear_end", {15'b0, rx_clear}, 16'd0);
  endtask

  task automatic ack_pulse();
    @(negedge clk); interrupt_ack = 1'b1;
    @(negedge clk); interrupt_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    int n;
    rst_out = 1'b1; port_id = '0; out_port = '0; write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; rx_rdy = 1'b0; rx_data = '0; rx_perr = 1'b0; rx_ferr = 1'b0;
    rx_ovf = 1'b0; tx_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst_out = 1'b0;

    // Reset state
    check("rst_interrupt", {15'b0, interrupt}, 16'd0);
    check("rst_tx_load", {15'b0, tx_load}, 16'd0);
    rdchk(R_STATUS, 16'h0042, "rst_status");
    rdchk(R_LEVEL, 16'h0000, "rst_level");
    rdchk(R_CTRL, 16'h0000, "rst_ctrl");
    @(negedge clk); port_id = BASE + 16'd4;
    #1 check("unmapped_read", in_port, 16'h0000);

    // Three characters through a 10-cycle-busy engine
    for (int i = 0; i < 3; i++) begin
      exp_tx.push_back(8'h41 + 8'(i));
      wr(R_DATA, 16'h0041 + 16'(i));
    end
    n = 0;
    do begin
      rd(R_STATUS, s);
      n++;
    end while (!(s[6] && exp_tx.size() == 0) && n < 100);
    check("tx_idle_end", s, 16'h0042);
    check("tx_load_count", 16'(load_count), 16'd3);

    // TX overflow and sticky tx_drop, then flush
    tx_hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_tx.push_back(8'h60 + 8'(i));
      wr(R_DATA, 16'h0060 + 16'(i));
    end
    rdchk(R_LEVEL, 16'h1000, "tx_full_level");
    rdchk(R_STATUS, 16'h0100, "tx_drop_set");
    rdchk(R_STATUS, 16'h0000, "tx_drop_cleared");
    wr(R_CTRL, 16'h0008);
    exp_tx.delete();
    rdchk(R_LEVEL, 16'h0000, "tx_flush_level");
    rdchk(R_CTRL, 16'h0000, "flush_reads_zero");
    rdchk(R_STATUS, 16'h0042, "tx_flush_status");
    tx_hold = 1'b0;

    // RX threshold interrupt and head error flags
    wr(R_CTRL, 16'h0401);
    rdchk(R_CTRL, 16'h0401, "ctrl_readback");
    exp_rx.push_back(8'h11); inject(8'h11, 1'b0, 1'b0, 1'b0);
    exp_rx.push_back(8'h22); inject(8'h22, 1'b1, 1'b0, 1'b0);
    exp_rx.push_back(8'h33); inject(8'h33, 1'b0, 1'b1, 1'b1);
    check("irq_below_thresh", {15'b0, interrupt}, 16'd0);
    exp_rx.push_back(8'h44); inject(8'h44, 1'b0, 1'b0, 1'b0);
    check("irq_latency_1", {15'b0, interrupt}, 16'd0);
    @(negedge clk);
    check("irq_latency_2", {15'b0, interrupt}, 16'd1);
    rdchk(R_LEVEL, 16'h0004, "rx_level4");
    rdchk(R_STATUS, 16'h0043, "head1_status");
    rd(R_DATA, s);
    rdchk(R_STATUS, 16'h0047, "head2_perr");
    rd(R_DATA, s);
    rdchk(R_STATUS, 16'h005B, "head3_ferr_ovf");
    rd(R_DATA, s);
    rdchk(R_STATUS, 16'h0043, "head4_status");
    rd(R_DATA, s);
    rdchk(R_STATUS, 16'h0042, "rx_empty_status");
    ack_pulse();
    check("irq_ack", {15'b0, interrupt}, 16'd0);

    // RX full: read+push in same cycle keeps count; push alone drops
    wr(R_CTRL, 16'h0004);
    for (int i = 0; i < 16; i++) begin
      exp_rx.push_back(8'h80 + 8'(i));
      inject(8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    end
    rdchk(R_LEVEL, 16'h0010, "rx_full_level");
    rdchk(R_STATUS, 16'h00C3, "rx_full_status");
    check("irq_idle_full", {15'b0, interrupt}, 16'd0);
    @(negedge clk);
    exp_rx.push_back(8'hA5);
    rx_data = 8'hA5; rx_rdy = 1'b1; port_id = BASE; read_strobe = 1'b1;
    @(negedge clk);
    rx_rdy = 1'b0; read_strobe = 1'b0;
    check("rx_clear_simul", {15'b0, rx_clear}, 16'd1);
    rdchk(R_LEVEL, 16'h0010, "rx_simul_level");
    rdchk(R_STATUS, 16'h00C3, "rx_simul_nodrop");
    inject(8'hB6, 1'b0, 1'b0, 1'b0);
    check("err_irq_latency", {15'b0, interrupt}, 16'd0);
    @(negedge clk);
    check("err_irq", {15'b0, interrupt}, 16'd1);
    rdchk(R_STATUS, 16'h00E3, "rx_drop_set");
    rdchk(R_STATUS, 16'h00C3, "rx_drop_cleared");
    for (int i = 0; i < 16; i++) rd(R_DATA, s);
    rdchk(R_STATUS, 16'h0042, "rx_drained");

    // Ack coinciding with a new source edge
    ack_pulse();
    check("ack_before_edge", {15'b0, interrupt}, 16'd0);
    wr(R_CTRL, 16'h0002);
    ack_pulse();
    check("set_beats_ack", {15'b0, interrupt}, 16'd1);
    ack_pulse();
    check("ack_no_edge", {15'b0, interrupt}, 16'd0);

    // Reset while the engine is busy with a character
    exp_tx.push_back(8'h55);
    wr(R_DATA, 16'h0055);
    wr(R_DATA, 16'h0066);
    repeat (4) @(negedge clk);
    check("first_char_sent", 16'(exp_tx.size()), 16'd0);
    @(negedge clk); rst_out = 1'b1;
    #1;
    check("rst_wait_tx_load", {15'b0, tx_load}, 16'd0);
    check("rst_wait_tx_data", {8'h00, tx_data}, 16'h0000);
    check("rst_wait_irq", {15'b0, interrupt}, 16'd0);
    check("rst_wait_rx_clear", {15'b0, rx_clear}, 16'd0);
    repeat (2) @(negedge clk);
    rst_out = 1'b0;
    rdchk(R_LEVEL, 16'h0000, "rst_wait_level");
    rdchk(R_STATUS, 16'h0042, "rst_wait_status");
    rdchk(R_CTRL, 16'h0000, "rst_wait_ctrl");
    repeat (20) @(negedge clk);
    check("tx_queue_empty", 16'(exp_tx.size()), 16'd0);
    check("rx_queue_empty", 16'(exp_rx.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Port-mapped buffering and interrupt bridge between the TramelBlaze I/O bus and the UART transmit/receive engines.
- Replaces the fixed load/clear decode, PEDs, SR interrupt flop and data/status mux with a parametrised TX FIFO and RX FIFO, a programmable base address, a maskable multi-source interrupt and sticky overrun status.
- The processor services bursts of characters per interrupt instead of one.

Parameters:
- DATA_W, 8, character width, 5..8; stored zero-extended in 16-bit reads.
- DEPTH, 16, entries per FIFO; power of two, 2..128.
- BASE_ADDR, 16'h0000, port_id of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
- CW (localparam), clog2(DEPTH)+1, FIFO count width.

Ports:
- clk in 1: system clock.
- rst_out in 1: reset.
- port_id in 16: processor port address.
- out_port in 16: processor write data.
- write_strobe in 1: one-cycle write qualifier.
- read_strobe in 1: one-cycle read qualifier.
- interrupt_ack in 1: clears interrupt.
- in_port out 16: read data, combinational from port_id.
- interrupt out 1: registered interrupt request.
- tx_load out 1: one-cycle pulse to the transmit engine.
- tx_data out DATA_W: character presented with tx_load.
- tx_rdy in 1: transmit engine idle.
- rx_rdy in 1: receive engine holding a character.
- rx_data in DATA_W: received character.
- rx_perr in 1: parity error flag from the receive engine.
- rx_ferr in 1: framing error flag from the receive engine.
- rx_ovf in 1: overflow error flag from the receive engine.
- rx_clear out 1: one-cycle pulse acknowledging the engine (reads0).

Behaviour:
- Reset: reset rst_out, asynchronous, active-high; clock clk.
  - Outputs go to 0; FIFOs empty; pointers 0; control register 0; sticky bits 0; TX FSM to IDLE.
  - Reset mid-character drops all queued data.
- Register map, offset from BASE_ADDR:
  - 0 DATA: write pushes out_port[DATA_W-1:0] to the TX FIFO; read returns the RX head (first-word fall-through) and pops it on read_strobe.
  - 1 STATUS, read only:
    - b0 rx_not_empty
    - b1 tx_not_full
    - b2 head perr
    - b3 head ferr
    - b4 head engine ovf
    - b5 rx_drop (sticky)
    - b6 tx_idle: TX FIFO empty and FSM IDLE
    - b7 rx_full
    - b8 tx_drop (sticky)
    - b15:9 = 0
    - A read_strobe on STATUS clears b5 and b8 next cycle. A new drop in the same cycle keeps the bit set.
  - 2 CONTROL, read/write:
    - b0 rx_ie, b1 tx_ie, b2 err_ie.
    - b3 tx_flush and b4 rx_flush: self-clearing; each empties its FIFO next cycle; read as 0.
    - b15:8 rx_thresh: value 0 is treated as 1; values above DEPTH saturate to DEPTH.
  - 3 LEVEL: [7:0] RX count, [15:8] TX count; zero-extended.
  - Unmapped port_id: in_port = 0; writes are ignored.
- TX path, FSM:
  - IDLE: if the TX FIFO is not empty and tx_rdy = 1, go to LOAD.
  - LOAD: one cycle; tx_load = 1, tx_data = head, pop; go to WAIT.
  - WAIT: stay until tx_rdy is seen 0 and then 1; go to IDLE.
  - A flush during LOAD/WAIT completes the current character.
  - A write when full is dropped and sets tx_drop. A write when full in the same cycle as a LOAD pop is accepted.
- RX path:
  - A rising edge of rx_rdy (registered detect) pushes {rx_ovf, rx_ferr, rx_perr, rx_data}, 3+DATA_W bits. rx_clear pulses the following cycle, pushed or not.
  - If full and no pop in that cycle: the character is dropped and rx_drop is set.
  - Push and pop in the same cycle: both occur; count is unchanged.
  - A flush concurrent with a push: flush wins, FIFO ends empty.
- Interrupt:
  - Sources:
    - rx_src = rx_ie & (rx_count >= rx_thresh)
    - tx_src = tx_ie & tx_idle
    - err_src = err_ie & (rx_drop | tx_drop)
  - any_src = OR of the sources; registered rising edge of any_src sets interrupt.
  - interrupt_ack clears it; set wins over a simultaneous ack.
  - Latency: source condition to interrupt = 2 cycles.
- Arithmetic: pointers wrap modulo DEPTH; counts range 0..DEPTH and never exceed DEPTH.

Decomposition:
- Shared package uart_pkg:
  - Register offsets: REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_LEVEL=3.
  - STATUS and CONTROL bit-index constants.
  - TX FSM state typedef: IDLE/LOAD/WAIT.
- One sub-module: sync_fifo (WIDTH, DEPTH; push, pop, flush, dout, count, full, empty).
  - Instantiated twice: TX with width DATA_W, RX with width DATA_W+3.

Test Plan:
- Reset, then read all registers → STATUS = 16'h0042 (tx_not_full, tx_idle), LEVEL = 0, CONTROL = 0, interrupt = 0, tx_load = 0.
- Write 3 chars 8'h41, 8'h42, 8'h43 with tx_rdy modelled at 10-cycle busy → three tx_load pulses in order; each waits for a tx_rdy 0→1; tx_idle returns to 1.
- DEPTH = 16: write 17 chars while tx_rdy = 0 → LEVEL[15:8] = 16, STATUS b8 = 1; after a STATUS read, b8 = 0.
- rx_thresh = 4, rx_ie = 1: inject 4 rx_rdy edges, the 2nd with rx_perr → interrupt asserts 2 cycles after the 4th push; rx_clear follows each push by 1 cycle; DATA reads return the data in order; STATUS b2 = 1 only while the 2nd char is at the head.
- RX full plus an injected char while simultaneously reading DATA → no drop, count stays 16; the same injection without the read → rx_drop = 1, and with err_ie = 1 interrupt asserts.
- Assert interrupt_ack on the same cycle as a new source edge → interrupt stays 1. Assert rst_out mid-WAIT → all outputs 0, FIFOs empty.
